xdma_c2h_stream_mux: RTL

XDMA_C2H_STREAM_MUX -- requirements
Module: xdma_c2h_stream_mux

---
 rtl/xdma_stream_pkg.sv | 28 ++
 rtl/xdma_rr_arbiter.sv | 48 ++++
 rtl/xdma_c2h_stream_mux.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/xdma_stream_pkg.sv
// Shared types and constants for the XDMA C2H stream multiplexer.
// Header layout is used only when XDMA_C2H_HDR_EN is defined.
package xdma_stream_pkg;

   localparam int unsigned CNT_W         = 16;
   localparam int unsigned SEQ_W         = 16;
   localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
   localparam int unsigned HDR_CH_LSB    = 0;
   localparam int unsigned HDR_SEQ_LSB   = 8;
   localparam int unsigned HDR_MAGIC_LSB = 24;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_DROP
   } state_e;

   function automatic logic [31:0] hdr_word(input logic [7:0] ch, input logic [SEQ_W-1:0] seq);
      logic [31:0] w;
      w = '0;
      w[HDR_CH_LSB    +: 8]     = ch;
      w[HDR_SEQ_LSB   +: SEQ_W] = seq;
      w[HDR_MAGIC_LSB +: 8]     = HDR_MAGIC;
      return w;
   endfunction

endpackage

// File: rtl/xdma_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last-granted+1,
// pointer advances only on an enable pulse with at least one request.
module xdma_rr_arbiter
#(
   parameter int unsigned NUM_CH = 4,
   localparam int unsigned IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NUM_CH-1:0] req_i,
   input  logic              en_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [IW-1:0]     gnt_idx_o
);

   logic [IW-1:0] ptr_q;
   logic          found;
   logic [IW-1:0] ci;
   int unsigned   c;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      ci        = '0;
      c         = 0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         c = 32'(ptr_q) + i;
         if (c >= NUM_CH) c = c - NUM_CH;
         ci = IW'(c);
         if (!found && req_i[ci]) begin
            found     = 1'b1;
            gnt_o[ci] = 1'b1;
            gnt_idx_o = ci;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= IW'(NUM_CH - 1);
      end else if (en_i && found) begin
         ptr_q <= gnt_idx_o;
      end
   end

endmodule

// File: rtl/xdma_c2h_stream_mux.sv
// Packet-atomic round-robin merge of NUM_CH AXI streams onto one XDMA C2H stream,
// with MAX_BEATS truncation. Define XDMA_C2H_HDR_EN to prepend a header beat per packet.
module xdma_c2h_stream_mux
   import xdma_stream_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MAX_BEATS  = 256
)
(
   input  logic                         user_clk,
   input  logic                         user_resetn,
   input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_CH*DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [NUM_CH-1:0]            s_axis_tlast,
   input  logic [NUM_CH-1:0]            s_axis_tvalid,
   output logic [NUM_CH-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]        m_axis_c2h_tdata,
   output logic [DATA_WIDTH/8-1:0]      m_axis_c2h_tkeep,
   output logic                         m_axis_c2h_tlast,
   output logic                         m_axis_c2h_tvalid,
   input  logic                         m_axis_c2h_tready,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic                         err_clr,
   output logic [NUM_CH-1:0]            trunc_err
);

   localparam int unsigned KW = DATA_WIDTH / 8;
   localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

   state_e                state_q;
   logic [IW-1:0]         gidx_q;
   logic [CNT_W-1:0]      beat_q;
   logic [SEQ_W-1:0]      seq_q [NUM_CH];
   logic [NUM_CH-1:0]     trunc_q;
   logic                  m_valid_q;
   logic                  m_last_q;
   logic [DATA_WIDTH-1:0] m_data_q;
   logic [KW-1:0]         m_keep_q;

   logic [NUM_CH-1:0]     req;
   logic [NUM_CH-1:0]     arb_gnt;
   logic [IW-1:0]         arb_idx;
   logic                  grant_en;
   logic                  out_free;
   logic                  src_valid;
   logic                  src_last;
   logic                  src_fire;
   logic [DATA_WIDTH-1:0] src_data;
   logic [KW-1:0]         src_keep;
   logic [NUM_CH-1:0]     trunc_set;

   assign req      = s_axis_tvalid & ch_enable;
   assign grant_en = (state_q == ST_IDLE) && (|arb_gnt);

   xdma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk_i     (user_clk),
      .rst_ni    (user_resetn),
      .req_i     (req),
      .en_i      (grant_en),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx)
   );

   assign out_free  = !m_valid_q || m_axis_c2h_tready;
   assign src_valid = s_axis_tvalid[gidx_q];
   assign src_last  = s_axis_tlast[gidx_q];
   assign src_data  = s_axis_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
   assign src_keep  = s_axis_tkeep[gidx_q*KW +: KW];
   assign src_fire  = src_valid && s_axis_tready[gidx_q];

   always_comb begin
      s_axis_tready = '0;
      if (state_q == ST_DATA)      s_axis_tready[gidx_q] = out_free;
      else if (state_q == ST_DROP) s_axis_tready[gidx_q] = 1'b1;
   end

   always_comb begin
      trunc_set = '0;
      if (state_q == ST_DATA && src_fire && !src_last && beat_q == LAST_BEAT)
         trunc_set[gidx_q] = 1'b1;
   end

   always_ff @(posedge user_clk or negedge user_resetn) begin
      if (!user_resetn) begin
         state_q   <= ST_IDLE;
         gidx_q    <= '0;
         beat_q    <= '0;
         seq_q     <= '{default: '0};
         trunc_q   <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
      end else begin
         // a same-cycle truncation wins over err_clr
         trunc_q <= (err_clr ? '0 : trunc_q) | trunc_set;
         if (out_free) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (grant_en) begin
                  gidx_q <= arb_idx;
                  beat_q <= '0;
`ifdef XDMA_C2H_HDR_EN
                  state_q <= ST_HDR;
`else
                  state_q <= ST_DATA;
`endif
               end
            end
`ifdef XDMA_C2H_HDR_EN
            ST_HDR: begin
               if (out_free) begin
                  m_valid_q <= 1'b1;
                  m_last_q  <= 1'b0;
                  m_keep_q  <= '1;
                  m_data_q  <= DATA_WIDTH'(hdr_word(8'(gidx_q), seq_q[gidx_q]));
                  state_q   <= ST_DATA;
               end
            end
`endif
            ST_DATA: begin
               if (src_fire) begin
                  m_valid_q <= 1'b1;
                  m_data_q  <= src_data;
                  m_keep_q  <= src_keep;
                  beat_q    <= beat_q + 1'b1;
                  if (src_last || beat_q == LAST_BEAT) begin
                     m_last_q       <= 1'b1;
                     seq_q[gidx_q]  <= seq_q[gidx_q] + 1'b1;
                     state_q        <= src_last ? ST_IDLE : ST_DROP;
                  end else begin
                     m_last_q <= 1'b0;
                  end
               end
            end
            ST_DROP: begin
               if (src_valid && src_last) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign m_axis_c2h_tvalid = m_valid_q;
   assign m_axis_c2h_tlast  = m_last_q;
   assign m_axis_c2h_tdata  = m_data_q;
   assign m_axis_c2h_tkeep  = m_keep_q;
   assign trunc_err         = trunc_q;

endmodule
